// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instruction pointer step, instruction memory read port and
// the valid/ready handshake towards decode.
interface instr_fetch_if #(
   parameter int INS_ADDR_SIZE = 8,
   parameter int INS_SIZE      = 16
);
   logic [INS_ADDR_SIZE-1:0] ip_in;
   logic                     ip_advance;
   logic                     flush;
   logic [INS_ADDR_SIZE-1:0] mem_addr;
   logic                     mem_rd;
   logic [INS_SIZE-1:0]      mem_data;
   logic [INS_SIZE-1:0]      instr;
   logic [INS_ADDR_SIZE-1:0] instr_addr;
   logic                     instr_valid;
   logic                     instr_ready;

   // master: the fetch stage; slave: pointer, memory and decode around it
   modport master (
      input  ip_in, flush, mem_data, instr_ready,
      output ip_advance, mem_addr, mem_rd, instr, instr_addr, instr_valid
   );
   modport slave (
      output ip_in, flush, mem_data, instr_ready,
      input  ip_advance, mem_addr, mem_rd, instr, instr_addr, instr_valid
   );
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: issues the IP to instruction memory whenever a buffer slot is
// free, tags returned words with their address and queues them in a 2-entry FIFO.
module instr_fetch #(
   parameter int INS_ADDR_SIZE = 8,
   parameter int INS_SIZE      = 16
) (
   input  logic          clk,
   input  logic          reset_n,
   instr_fetch_if.master bus
);
   typedef struct packed {
      logic [INS_SIZE-1:0]      ins;
      logic [INS_ADDR_SIZE-1:0] addr;
   } entry_t;

   entry_t                   fifo [2];
   logic [1:0]               count;
   logic                     inflight;
   logic [INS_ADDR_SIZE-1:0] inflight_addr;
   logic                     rd_ptr, wr_ptr;
   logic                     valid, pop, push, issue;
   logic [2:0]               occ;

   assign valid = (count != 2'd0);
   assign pop   = valid & bus.instr_ready;
   assign push  = inflight & ~bus.flush;

   // Credit check: slots already claimed (buffered + outstanding) after this
   // cycle's pop; an outstanding read always has a home when it lands.
   assign occ   = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
   assign issue = reset_n & ~bus.flush & (occ < 3'd2);

   assign bus.mem_rd      = issue;
   assign bus.ip_advance  = issue;
   assign bus.mem_addr    = bus.ip_in;
   assign bus.instr_valid = valid;
   assign bus.instr       = fifo[rd_ptr].ins;
   assign bus.instr_addr  = fifo[rd_ptr].addr;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count         <= 2'd0;
         inflight      <= 1'b0;
         inflight_addr <= '0;
         rd_ptr        <= 1'b0;
         wr_ptr        <= 1'b0;
         fifo[0]       <= '0;
         fifo[1]       <= '0;
      end else if (bus.flush) begin
         // the response landing this cycle is simply never pushed
         count    <= 2'd0;
         inflight <= 1'b0;
         rd_ptr   <= 1'b0;
         wr_ptr   <= 1'b0;
      end else begin
         inflight <= issue;
         if (issue)
            inflight_addr <= bus.ip_in;
         if (push) begin
            fifo[wr_ptr] <= '{ins: bus.mem_data, addr: inflight_addr};
            wr_ptr       <= ~wr_ptr;
         end
         if (pop)
            rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: models the instruction pointer and memory around the
// DUT and checks delivery against a queue-based transaction model.
module tb_instr_fetch;
   localparam int AW = 8;
   localparam int DW = 16;

   logic clk = 1'b0;
   logic reset_n = 1'b1;

   instr_fetch_if #(.INS_ADDR_SIZE(AW), .INS_SIZE(DW)) bus ();
   instr_fetch #(.INS_ADDR_SIZE(AW), .INS_SIZE(DW)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] ins;
      logic [AW-1:0] addr;
   } ent_t;

   ent_t          mq[$];
   bit            m_inf;
   logic [AW-1:0] m_inf_addr;
   logic [AW-1:0] ip, redir, s_ip;
   logic [DW-1:0] key;
   int            n_cmp, n_err;

   bit            e_rd, e_valid, e_pop;
   logic [DW-1:0] e_instr;
   logic [AW-1:0] e_addr;
   logic          a_rd, a_adv, a_valid;
   logic [AW-1:0] a_maddr, a_iaddr;
   logic [DW-1:0] a_instr;
   bit            a_pop;

   function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
      return (16'h0100 + {8'h00, a}) ^ key;
   endfunction

   // One clock cycle: sample outputs and model expectations, take the edge,
   // then play pointer and memory and advance the model.
   task automatic step();
      #1;
      e_valid = (mq.size() != 0);
      e_pop   = e_valid && (bus.instr_ready === 1'b1);
      e_rd    = (reset_n === 1'b1) && (bus.flush !== 1'b1) &&
                (int'(mq.size()) + int'(m_inf) - int'(e_pop) < 2);
      if (e_valid) begin
         e_instr = mq[0].ins;
         e_addr  = mq[0].addr;
      end
      a_rd    = bus.mem_rd;
      a_adv   = bus.ip_advance;
      a_maddr = bus.mem_addr;
      a_valid = bus.instr_valid;
      a_instr = bus.instr;
      a_iaddr = bus.instr_addr;
      a_pop   = (a_valid === 1'b1) && (bus.instr_ready === 1'b1);
      s_ip    = ip;
      if (reset_n) begin
         n_cmp++;
         if (dut.count > 2'd2 || (dut.count == 2'd2 && dut.inflight && !bus.flush && !a_pop)) begin
            n_err++;
            $display("FAIL fifo_full_push: count=%0d inflight=%0b pop=%0b, required no push into full FIFO",
                     dut.count, dut.inflight, a_pop);
         end
      end
      @(posedge clk);
      #1;
      if (!reset_n || bus.flush) begin
         mq.delete();
         m_inf = 1'b0;
      end else begin
         if (e_pop) mq.delete(0);
         if (m_inf) mq.push_back('{ins: mem_val(m_inf_addr), addr: m_inf_addr});
         m_inf      = e_rd;
         m_inf_addr = ip;
      end
      if (bus.flush) ip = redir;
      else if (a_adv === 1'b1) ip = ip + 1'b1;
      bus.mem_data = (a_rd === 1'b1) ? mem_val(a_maddr) : 16'($urandom);
      bus.ip_in    = ip;
   endtask

   task automatic start(input logic [AW-1:0] ip0);
      reset_n   = 1'b0;
      bus.flush = 1'b0;
      ip        = ip0;
      bus.ip_in = ip0;
      step();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      bus.flush = 0; bus.instr_ready = 0; bus.mem_data = '0;
      ip = 8'h00; bus.ip_in = 8'h00; redir = '0; key = '0;
      m_inf = 0; m_inf_addr = '0;
      #2 reset_n = 1'b0;
      #1;
      n_cmp += 5;
      if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.instr_valid); end
      if (bus.instr !== 16'h0) begin n_err++; $display("FAIL reset_instr: got %h want 0000", bus.instr); end
      if (bus.instr_addr !== 8'h0) begin n_err++; $display("FAIL reset_addr: got %h want 00", bus.instr_addr); end
      if (bus.mem_rd !== 1'b0) begin n_err++; $display("FAIL reset_mem_rd: got %b want 0", bus.mem_rd); end
      if (bus.ip_advance !== 1'b0) begin n_err++; $display("FAIL reset_ip_advance: got %b want 0", bus.ip_advance); end
      step();
   endtask

   task automatic test_steady();
      logic [AW-1:0] exp;
      int first;
      start(8'h00);
      bus.instr_ready = 1;
      exp = 8'h00; first = -1;
      for (int c = 0; c < 20; c++) begin
         step();
         n_cmp++;
         if (a_adv !== 1'b1) begin n_err++; $display("FAIL steady_adv: cycle %0d got %b want 1", c, a_adv); end
         if (a_valid === 1'b1 && first < 0) first = c;
         if (a_pop) begin
            n_cmp++;
            if (a_iaddr !== exp || a_instr !== mem_val(exp)) begin
               n_err++;
               $display("FAIL steady_data: got %h/%h want %h/%h", a_iaddr, a_instr, exp, mem_val(exp));
            end
            exp++;
         end
      end
      n_cmp += 2;
      if (first !== 2) begin n_err++; $display("FAIL steady_first_valid: got cycle %0d want 2", first); end
      if (exp !== 8'd18) begin n_err++; $display("FAIL steady_count: got %0d want 18", exp); end
   endtask

   task automatic test_backpressure();
      int nrd;
      logic [AW-1:0] exp;
      start(8'h00);
      bus.instr_ready = 0;
      nrd = 0;
      for (int c = 0; c < 6; c++) begin
         step();
         if (a_rd === 1'b1) nrd++;
      end
      n_cmp += 5;
      if (nrd !== 2) begin n_err++; $display("FAIL bp_reads: got %0d want 2", nrd); end
      if (dut.count !== 2'd2) begin n_err++; $display("FAIL bp_count: got %0d want 2", dut.count); end
      if (a_valid !== 1'b1 || a_iaddr !== 8'h00) begin n_err++; $display("FAIL bp_head_addr: got v%b %h want v1 00", a_valid, a_iaddr); end
      if (a_instr !== 16'h0100) begin n_err++; $display("FAIL bp_head_instr: got %h want 0100", a_instr); end
      if (ip !== 8'h02) begin n_err++; $display("FAIL bp_ip: got %h want 02", ip); end
      bus.instr_ready = 1;
      exp = 8'h00;
      for (int c = 0; c < 10; c++) begin
         step();
         if (c == 0) begin
            n_cmp++;
            if (a_rd !== 1'b1) begin n_err++; $display("FAIL bp_resume_rd: got %b want 1", a_rd); end
         end
         n_cmp++;
         if (!a_pop || a_iaddr !== exp || a_instr !== mem_val(exp)) begin
            n_err++;
            $display("FAIL bp_release: cycle %0d got pop%b %h/%h want %h/%h", c, a_pop, a_iaddr, a_instr, exp, mem_val(exp));
         end
         exp++;
      end
   endtask

   task automatic test_flush();
      logic [AW-1:0] exp;
      int first;
      start(8'h00);
      bus.instr_ready = 1;
      repeat (5) step();
      bus.instr_ready = 0;
      bus.flush = 1;
      redir = 8'h20;
      step();
      n_cmp += 2;
      if (a_rd !== 1'b0) begin n_err++; $display("FAIL flush_mem_rd: got %b want 0", a_rd); end
      if (a_adv !== 1'b0) begin n_err++; $display("FAIL flush_ip_advance: got %b want 0", a_adv); end
      bus.flush = 0;
      bus.instr_ready = 1;
      exp = 8'h20; first = -1;
      for (int c = 0; c < 8; c++) begin
         step();
         if (c == 0) begin
            n_cmp++;
            if (a_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid_next: got %b want 0", a_valid); end
         end
         if (a_valid === 1'b1 && first < 0) first = c;
         if (a_pop) begin
            n_cmp++;
            if (a_iaddr !== exp || a_instr !== mem_val(exp)) begin
               n_err++;
               $display("FAIL flush_stream: got %h/%h want %h/%h", a_iaddr, a_instr, exp, mem_val(exp));
            end
            exp++;
         end
      end
      n_cmp++;
      if (first !== 2) begin n_err++; $display("FAIL flush_first_valid: got F+%0d want F+3", first + 1); end
   endtask

   task automatic test_async_reset();
      logic [AW-1:0] exp;
      int first;
      start(8'h00);
      bus.instr_ready = 1;
      repeat (6) step();
      #4 reset_n = 1'b0;
      #1;
      n_cmp += 3;
      if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL areset_valid: got %b want 0", bus.instr_valid); end
      if (bus.mem_rd !== 1'b0) begin n_err++; $display("FAIL areset_mem_rd: got %b want 0", bus.mem_rd); end
      if (bus.ip_advance !== 1'b0) begin n_err++; $display("FAIL areset_ip_advance: got %b want 0", bus.ip_advance); end
      ip = 8'h40; bus.ip_in = 8'h40;
      step();
      reset_n = 1'b1;
      exp = 8'h40; first = -1;
      for (int c = 0; c < 10; c++) begin
         step();
         if (a_valid === 1'b1 && first < 0) first = c;
         if (a_pop) begin
            n_cmp++;
            if (a_iaddr !== exp || a_instr !== mem_val(exp)) begin
               n_err++;
               $display("FAIL areset_stream: got %h/%h want %h/%h", a_iaddr, a_instr, exp, mem_val(exp));
            end
            exp++;
         end
      end
      n_cmp++;
      if (first !== 2) begin n_err++; $display("FAIL areset_first_valid: got cycle %0d want 2", first); end
   endtask

   task automatic test_wrap();
      logic [AW-1:0] want_a [4];
      logic [DW-1:0] want_d [4];
      int k;
      want_a = '{8'hFE, 8'hFF, 8'h00, 8'h01};
      want_d = '{16'h01FE, 16'h01FF, 16'h0100, 16'h0101};
      start(8'hFE);
      bus.instr_ready = 1;
      k = 0;
      for (int c = 0; c < 8; c++) begin
         step();
         if (a_pop && k < 4) begin
            n_cmp++;
            if (a_iaddr !== want_a[k] || a_instr !== want_d[k]) begin
               n_err++;
               $display("FAIL wrap_%0d: got %h/%h want %h/%h", k, a_iaddr, a_instr, want_a[k], want_d[k]);
            end
            k++;
         end
      end
      n_cmp++;
      if (k !== 4) begin n_err++; $display("FAIL wrap_count: got %0d want 4", k); end
   endtask

   task automatic test_random();
      int npop;
      key = 16'($urandom);
      start(8'($urandom));
      npop = 0;
      for (int c = 0; c < 1000; c++) begin
         bus.instr_ready = 1'($urandom_range(0, 1));
         bus.flush = ($urandom_range(0, 39) == 0);
         redir = 8'($urandom);
         step();
         n_cmp += 4;
         if (a_rd !== e_rd) begin n_err++; $display("FAIL rnd_mem_rd: cycle %0d got %b want %b", c, a_rd, e_rd); end
         if (a_adv !== e_rd) begin n_err++; $display("FAIL rnd_ip_advance: cycle %0d got %b want %b", c, a_adv, e_rd); end
         if (a_maddr !== s_ip) begin n_err++; $display("FAIL rnd_mem_addr: cycle %0d got %h want %h", c, a_maddr, s_ip); end
         if (a_valid !== e_valid) begin n_err++; $display("FAIL rnd_valid: cycle %0d got %b want %b", c, a_valid, e_valid); end
         if (e_valid) begin
            n_cmp++;
            if (a_iaddr !== e_addr || a_instr !== e_instr) begin
               n_err++;
               $display("FAIL rnd_head: cycle %0d got %h/%h want %h/%h", c, a_iaddr, a_instr, e_addr, e_instr);
            end
         end
         if (a_pop) npop++;
      end
      bus.flush = 0;
      n_cmp++;
      if (npop < 200) begin n_err++; $display("FAIL rnd_throughput: got %0d deliveries want >= 200", npop); end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      n_cmp = 0; n_err = 0;
      test_reset();
      test_steady();
      test_backpressure();
      test_flush();
      test_async_reset();
      test_wrap();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
